// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and constants for the spike encoder
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    MARK,
    FIN
  } enc_state_t;

  typedef enum logic {
    EVT_SPIKE    = 1'b0,
    EVT_STEP_END = 1'b1
  } evt_type_t;

  // Accumulators start half-full so a pixel's spikes are centred in the window
  function automatic int acc_init(input int pixel_bits);
    return 1 << (pixel_bits - 1);
  endfunction

  localparam int ACC_INIT = acc_init(8);

endpackage

// File: rtl/spike_evt_slot.sv
// rtl/spike_evt_slot.sv - one-entry registered valid/ready event stage
module spike_evt_slot #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 load,
  input  logic                 load_type,
  input  logic [ADDR_BITS-1:0] load_addr,
  output logic                 valid,
  input  logic                 ready,
  output logic                 evt_type,
  output logic [ADDR_BITS-1:0] evt_addr,
  output logic                 free
);

  assign free = !valid || ready;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      valid    <= 1'b0;
      evt_type <= 1'b0;
      evt_addr <= '0;
    end else if (free) begin
      valid <= load;
      if (load) begin
        evt_type <= load_type;
        evt_addr <= load_addr;
      end
    end
  end

endmodule

// File: rtl/image_spike_encoder.sv
// rtl/image_spike_encoder.sv - rate-codes a snapshotted image into spike/marker events
module image_spike_encoder
  import snn_pkg::*;
#(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = 8,
  parameter int NUM_TIMESTEPS   = 16,
  parameter int STEP_BITS       = $clog2(NUM_TIMESTEPS)
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0]  IMAGE,
  input  logic                                   NEW_IMAGE,
  output logic                                   EVT_VALID,
  input  logic                                   EVT_READY,
  output logic                                   EVT_TYPE,
  output logic [IMAGE_SIZE_BITS-1:0]             EVT_ADDR,
  output logic                                   BUSY,
  output logic                                   DONE
);

  localparam logic [PIXEL_BITS-1:0]      ACC_START = PIXEL_BITS'(acc_init(PIXEL_BITS));
  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [STEP_BITS-1:0]       LAST_STEP = STEP_BITS'(NUM_TIMESTEPS - 1);

  enc_state_t                            state;
  logic                                  nimg_q;
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] snap;
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] acc;
  logic [IMAGE_SIZE_BITS-1:0]            idx;
  logic [STEP_BITS-1:0]                  step;
  logic [PIXEL_BITS:0]                   sum;
  logic                                  slot_free;
  logic                                  slot_load;
  evt_type_t                             slot_type;
  logic [IMAGE_SIZE_BITS-1:0]            slot_addr;

  // The carry out of the accumulator is the spike
  always_comb begin
    sum       = {1'b0, acc[idx]} + {1'b0, snap[idx]};
    slot_load = 1'b0;
    slot_type = EVT_SPIKE;
    slot_addr = idx;
    case (state)
      SCAN: slot_load = slot_free && sum[PIXEL_BITS];
      MARK: begin
        slot_load = slot_free;
        slot_type = EVT_STEP_END;
        slot_addr = IMAGE_SIZE_BITS'(step);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state  <= IDLE;
      nimg_q <= 1'b1;
      snap   <= '0;
      acc    <= '0;
      idx    <= '0;
      step   <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      nimg_q <= NEW_IMAGE;
      DONE   <= 1'b0;
      case (state)
        IDLE: begin
          if (NEW_IMAGE && !nimg_q) begin
            state <= LOAD;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          snap  <= IMAGE;
          acc   <= {IMAGE_SIZE{ACC_START}};
          idx   <= '0;
          step  <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (slot_free) begin
            acc[idx] <= sum[PIXEL_BITS-1:0];
            idx      <= idx + IMAGE_SIZE_BITS'(1);
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= MARK;
            end
          end
        end
        MARK: begin
          if (slot_free) begin
            if (step == LAST_STEP) begin
              state <= FIN;
            end else begin
              step  <= step + STEP_BITS'(1);
              state <= SCAN;
            end
          end
        end
        FIN: begin
          if (slot_free) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spike_evt_slot #(
    .ADDR_BITS (IMAGE_SIZE_BITS)
  ) u_slot (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load      (slot_load),
    .load_type (slot_type),
    .load_addr (slot_addr),
    .valid     (EVT_VALID),
    .ready     (EVT_READY),
    .evt_type  (EVT_TYPE),
    .evt_addr  (EVT_ADDR),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_image_spike_encoder.sv
// tb/tb_image_spike_encoder.sv - scoreboard bench for image_spike_encoder
module tb_image_spike_encoder;

  logic                 ACLK = 1'b0;
  logic                 ARESETN = 1'b0;
  logic [255:0][7:0]    IMAGE = '0;
  logic                 NEW_IMAGE = 1'b1;
  logic                 EVT_VALID;
  logic                 EVT_READY = 1'b1;
  logic                 EVT_TYPE;
  logic [7:0]           EVT_ADDR;
  logic                 BUSY;
  logic                 DONE;

  image_spike_encoder dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .IMAGE     (IMAGE),
    .NEW_IMAGE (NEW_IMAGE),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_TYPE  (EVT_TYPE),
    .EVT_ADDR  (EVT_ADDR),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 ACLK = ~ACLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [8:0] exp_q[$];
  int         ev_cnt = 0;
  int         done_cnt = 0;
  int         marker_seen = 0;
  int         last_hs_cyc = 0;
  int         last_mark_cyc = 0;
  int         lat_expect = 0;
  bit         lat_armed = 0;
  bit         ready_mode = 0;
  bit         prev_stall = 0;
  logic [8:0] prev_fields = '0;
  int         exp_n = 0;

  always @(posedge ACLK) cyc++;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Reference: pixel p spikes in step t when floor((128+N*p)/256) steps up
  function automatic int push_expected(input logic [255:0][7:0] img);
    int n = 0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 256; i++) begin
        int p = int'(img[i]);
        if ((128 + (t + 1) * p) / 256 != (128 + t * p) / 256) begin
          exp_q.push_back({1'b0, 8'(i)});
          n++;
        end
      end
      exp_q.push_back({1'b1, 8'(t)});
      n++;
    end
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      EVT_READY = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", EVT_VALID, 1);
        chk("hold_fields", {EVT_TYPE, EVT_ADDR}, prev_fields);
      end
      if (lat_armed && EVT_VALID) begin
        chk("first_event_latency", cyc, lat_expect);
        lat_armed = 0;
      end
      if (EVT_VALID && EVT_READY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got 0x%0h, expected no event", {EVT_TYPE, EVT_ADDR});
        end else begin
          chk("event", {EVT_TYPE, EVT_ADDR}, exp_q.pop_front());
        end
        ev_cnt++;
        last_hs_cyc = cyc;
        if (EVT_TYPE) begin
          if (!ready_mode && EVT_ADDR != 0) chk("step_period", cyc - last_mark_cyc, 257);
          last_mark_cyc = cyc;
          marker_seen++;
        end
      end
      if (DONE) begin
        done_cnt++;
        chk("done_timing", cyc, last_hs_cyc + 1);
        chk("done_queue_empty", exp_q.size(), 0);
      end
      prev_stall  = EVT_VALID && !EVT_READY;
      prev_fields = {EVT_TYPE, EVT_ADDR};
    end
  end

  task automatic start_run();
    exp_n       = push_expected(IMAGE);
    marker_seen = 0;
    NEW_IMAGE   = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    NEW_IMAGE  = 1'b1;
    lat_expect = cyc + 3;
    lat_armed  = (IMAGE[0] >= 8'd128);
  endtask

  task automatic wait_done(input string nm, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 30000) begin
      @(posedge ACLK);
      n++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no DONE after %0d cycles, expected DONE", nm, n);
    end
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  task automatic full_run(input string nm);
    int d0 = done_cnt;
    int e0 = ev_cnt;
    start_run();
    wait_done(nm, d0);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_event_count"}, ev_cnt - e0, exp_n);
    chk({nm, "_busy_idle"}, BUSY, 0);
  endtask

  initial begin
    int d0;
    int n;

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_valid", EVT_VALID, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_type", EVT_TYPE, 0);
    chk("reset_addr", EVT_ADDR, 0);
    ARESETN = 1'b1;
    repeat (6) @(posedge ACLK);
    #1;
    chk("no_start_from_high_level", BUSY, 0);

    ready_mode = 0;
    for (int i = 0; i < 256; i++) IMAGE[i] = 8'd255;
    full_run("all_255");
    chk("all_255_total", exp_n, 4112);

    IMAGE = '0;
    IMAGE[0] = 8'd128;
    full_run("pix0_128");
    chk("pix0_128_total", exp_n, 24);

    ready_mode = 1;
    IMAGE = '0;
    IMAGE[5] = 8'd16;
    full_run("pix5_16");

    for (int i = 0; i < 256; i++) IMAGE[i] = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    start_run();
    n = 0;
    while (marker_seen < 4 && n < 30000) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    for (int i = 0; i < 256; i++) IMAGE[i] = 8'($urandom_range(0, 255));
    NEW_IMAGE = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    NEW_IMAGE = 1'b1;
    wait_done("snapshot", d0);
    chk("snapshot_done_pulses", done_cnt - d0, 1);
    d0 = done_cnt;
    repeat (40) @(posedge ACLK);
    #1;
    chk("held_high_no_restart_busy", BUSY, 0);
    chk("held_high_no_restart_done", done_cnt - d0, 0);
    full_run("restart_edge");

    ready_mode = 0;
    for (int i = 0; i < 256; i++) IMAGE[i] = 8'd255;
    start_run();
    n = 0;
    while (marker_seen < 3 && n < 30000) begin
      @(posedge ACLK);
      n++;
    end
    chk("reached_step3", marker_seen >= 3, 1);
    repeat (20) @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    @(posedge ACLK);
    #1;
    chk("midreset_valid", EVT_VALID, 0);
    chk("midreset_busy", BUSY, 0);
    exp_q.delete();
    lat_armed = 0;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    full_run("after_reset");

    IMAGE = '0;
    full_run("all_zero");
    chk("all_zero_total", exp_n, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/image_spike_encoder.md
# image_spike_encoder

Rate-codes a received image into a stream of spike events for the SNN core. It sits directly downstream of the AXI4-Lite image register slave: it consumes the `IMAGE` pixel array and the `NEW_IMAGE` level, and runs a fixed number of timesteps. In each timestep it emits one event per spiking pixel, followed by one end-of-timestep marker, over a valid/ready handshake.

## Interface
Parameters:
- `IMAGE_SIZE`, 256: pixels per image.
- `IMAGE_SIZE_BITS`, `$clog2(IMAGE_SIZE)`: width of a pixel index.
- `PIXEL_BITS`, 8: pixel and accumulator width.
- `NUM_TIMESTEPS`, 16: timesteps per image.
- `STEP_BITS`, `$clog2(NUM_TIMESTEPS)`: width of the timestep counter.

Ports:
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  reset, synchronous, active-low.
- `IMAGE`  in  `PIXEL_BITS` x `IMAGE_SIZE`  pixel array from the AXI slave.
- `NEW_IMAGE`  in  1  level; its rising edge starts encoding.
- `EVT_VALID`  out  1  event valid.
- `EVT_READY`  in  1  event accepted by the SNN core.
- `EVT_TYPE`  out  1  0 = spike, 1 = end-of-timestep marker.
- `EVT_ADDR`  out  `IMAGE_SIZE_BITS`  pixel index for a spike; timestep index (zero-extended) for a marker.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse when the last event has been accepted.

## Operation
- **Start detection:** `nimg_q` registers `NEW_IMAGE`; its reset value is 1. A start occurs when `NEW_IMAGE` is 1 and `nimg_q` is 0, and only in IDLE. A rising edge in any other state is ignored and is not queued. A level already high after reset does not start encoding; the source must drop `NEW_IMAGE` and raise it again.
- **State machine:** IDLE -> LOAD -> SCAN <-> MARK -> FIN -> IDLE.
- **LOAD (1 cycle):**
  - Copy `IMAGE` into the internal buffer `snap`.
  - Set every `acc[i]` to 2^(`PIXEL_BITS`-1), which is 128.
  - Clear `idx` and `step`.
  - Later changes to `IMAGE` do not affect the current encoding.
- **SCAN:** pixel `idx` is processed in any cycle where the output slot is free (`!EVT_VALID || EVT_READY`).
  - Compute `sum = acc[idx] + snap[idx]`, `PIXEL_BITS`+1 bits wide.
  - Set `acc[idx] <= sum[PIXEL_BITS-1:0]`, i.e. the sum wraps modulo 256.
  - If `sum[PIXEL_BITS]` is set, load the slot with a spike event: type 0, address `idx`.
  - Increment `idx`. After pixel `IMAGE_SIZE`-1, `idx` wraps to 0 and the state becomes MARK.
  - If the slot is not free, hold and process nothing.
- **MARK:** when the slot is free, load a marker event (type 1, address `step`).
  - If `step == NUM_TIMESTEPS-1`, go to FIN.
  - Otherwise increment `step` and return to SCAN.
- **FIN:** wait until the slot is free, then pulse `DONE` for one cycle and return to IDLE.
- **Spike count:** pixel value p produces floor((128 + N·p)/256) spikes in N timesteps.
  - With 16 timesteps: p=255 gives 16 spikes, p=128 gives 8, p=16 gives 1 (at step 7), p=0 gives none.
- **Reset (including mid-operation):**
  - State returns to IDLE.
  - `EVT_VALID`, `BUSY` and `DONE` go to 0.
  - `EVT_TYPE` and `EVT_ADDR` go to 0.
  - `acc`, `snap`, `idx` and `step` are cleared.

## Timing
- **Start latency:** let k be the clock edge at which the start condition is sampled.
  - LOAD occurs in cycle k+1.
  - Pixel 0 is processed in cycle k+2.
  - If pixel 0 spikes, `EVT_VALID` is high from k+3.
- **Output:** the event slot is registered, with no combinational path from `EVT_READY` to `EVT_VALID`.
  - While `EVT_VALID && !EVT_READY`, `EVT_TYPE` and `EVT_ADDR` hold stable.
  - A slot can be consumed and refilled in the same cycle.
- **Throughput:** with `EVT_READY` held at 1, one pixel is processed per cycle, and each timestep lasts exactly `IMAGE_SIZE`+1 cycles.
- **Ordering:** within a timestep, spikes appear in ascending address order, followed by that timestep's marker.
- **Backpressure:** it stalls the scan only; the event sequence is identical for any `EVT_READY` pattern.
- **`DONE` timing:** `DONE` is asserted in the cycle after the final marker is accepted. `BUSY` falls in the same cycle.

## Structure
- **Shared package `snn_pkg`:** holds the state enum `enc_state_t` (IDLE, LOAD, SCAN, MARK, FIN), the event-type enum `evt_type_t` (`EVT_SPIKE`, `EVT_STEP_END`), and the constant `ACC_INIT` = 2^(`PIXEL_BITS`-1).
- **Sub-module `spike_evt_slot`:** one natural sub-module, a one-entry registered valid/ready holding stage. It outputs `free = !valid || ready` back to the FSM.

## Test plan
- **All pixels 255, `EVT_READY`=1:** 16 timesteps, each with 256 spikes at addresses 0..255 in order, then a marker with address = step. `DONE` pulses once, and total events = 4112.
- **Pixel 0 = 128, others 0:** spikes at address 0 only, in steps 0, 2, ..., 14 (8 spikes). 16 markers. Each step takes 257 cycles.
- **Pixel 5 = 16, random 50% `EVT_READY`:** exactly one spike (address 5) between marker 6 and marker 7. Event fields are stable whenever `VALID && !READY`.
- **Snapshot and start-edge rules:**
  - Rewriting `IMAGE` and re-raising `NEW_IMAGE` mid-encoding leaves the output unchanged and does not cause a second run.
  - `NEW_IMAGE` held high after `DONE` does not restart encoding.
  - A 0->1 transition on `NEW_IMAGE` does restart encoding.
- **Reset mid-SCAN (step 3):**
  - The cycle after the reset edge shows `EVT_VALID`=0 and `BUSY`=0.
  - A subsequent start yields the full sequence again from step 0.
- **All-zero image:** output is only markers 0..15. `DONE` pulses one cycle after the marker-15 handshake.
